line_sync_pulse_gen: RTL and testbench



---
 rtl/pal_timing_pkg.sv | 10 +
 rtl/sync_edge_detect.sv | 16 +
 rtl/line_sync_pulse_gen.sv | 98 +++++++++
 tb/tb_line_sync_pulse_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pal_timing_pkg.sv
// pal_timing_pkg: shared PAL line-timing types and constants.
package pal_timing_pkg;
  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_t;
  localparam int CLK_HZ    = 3579545;
  localparam int LINES_PAL = 312;
  localparam int PULSE_3US = 11;
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 3-flop synchroniser with polarity-selectable edge strobe.
module sync_edge_detect #(
  parameter bit EDGE_RISE = 1'b0,
  parameter bit RESET_LVL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sync,
  output logic o_trig
);
  logic [2:0] r_sync;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_sync <= {3{RESET_LVL}};
    else r_sync <= {r_sync[1:0], i_sync};
  assign o_trig = EDGE_RISE ? (~r_sync[2] & r_sync[1]) : (r_sync[2] & ~r_sync[1]);
endmodule

// File: rtl/line_sync_pulse_gen.sv
// line_sync_pulse_gen: sync-edge triggered fixed-width line pulse with holdoff,
// line counter, line parity and field toggle.
module line_sync_pulse_gen
  import pal_timing_pkg::*;
#(
  parameter int PULSE_LEN   = PULSE_3US,
  parameter int HOLDOFF_LEN = 200,
  parameter int LINES       = LINES_PAL,
  parameter bit EDGE_RISE   = 1'b0,
  localparam int CNT_W  = $clog2(max_int(PULSE_LEN, HOLDOFF_LEN) + 1),
  localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_sync,
  output logic              o_q,
  output logic              o_q2,
  output logic              o_field,
  output logic [LINE_W-1:0] o_line_cnt,
  output logic              o_busy,
  output logic              o_err
);
  localparam logic [CNT_W-1:0]  PULSE_INI = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0]  HOLD_INI  = (HOLDOFF_LEN > 0) ? CNT_W'(HOLDOFF_LEN - 1) : '0;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);
  localparam logic [LINE_W-1:0] LINE_ONE  = LINE_W'(1);
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [LINE_W-1:0] r_line;
  logic              r_q, r_q2, r_field, r_busy, r_err;
  logic              w_trig;
  sync_edge_detect #(.EDGE_RISE(EDGE_RISE), .RESET_LVL(!EDGE_RISE)) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_sync (i_sync),
    .o_trig (w_trig)
  );
  // One down-counter serves both the pulse width and the holdoff window.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_line  <= '0;
      r_q     <= 1'b1;
      r_q2    <= 1'b0;
      r_field <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (!i_en) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_q     <= 1'b1;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: if (w_trig) begin
            r_state <= PULSE;
            r_busy  <= 1'b1;
            r_q     <= 1'b0;
            r_cnt   <= PULSE_INI;
            r_line  <= (r_line == LINE_LAST) ? '0 : r_line + LINE_ONE;
            if (r_line == LINE_LAST) r_field <= ~r_field;
          end
          PULSE: begin
            r_err <= w_trig;
            if (r_cnt == '0) begin
              r_q     <= 1'b1;
              r_q2    <= ~r_q2;
              r_state <= (HOLDOFF_LEN > 0) ? HOLDOFF : IDLE;
              r_busy  <= (HOLDOFF_LEN > 0);
              r_cnt   <= HOLD_INI;
            end else r_cnt <= r_cnt - CNT_ONE;
          end
          HOLDOFF: begin
            r_err <= w_trig;
            if (r_cnt == '0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else r_cnt <= r_cnt - CNT_ONE;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  assign o_q        = r_q;
  assign o_q2       = r_q2;
  assign o_field    = r_field;
  assign o_line_cnt = r_line;
  assign o_busy     = r_busy;
  assign o_err      = r_err;
endmodule

// File: tb/tb_line_sync_pulse_gen.sv
// tb_line_sync_pulse_gen: timestamp-based reference model plus directed and random stimulus
// for a default-parameter instance and a rising-edge, 1-cycle, no-holdoff instance.
module tb_line_sync_pulse_gen;
  localparam int PA = 11, HA = 200, LA = 312;
  localparam int PB = 1, HB = 0, LB = 4;
  typedef struct {
    bit s1, s2, s3, active, q, q2, field, busy, err;
    int t, line;
  } mdl_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en_a = 1'b0, sync_a = 1'b1, en_b = 1'b0, sync_b = 1'b0;
  logic q_a, q2_a, field_a, busy_a, err_a, q_b, q2_b, field_b, busy_b, err_b;
  logic [8:0] line_a;
  logic [1:0] line_b;
  mdl_t m [2];
  int tests = 0, fails = 0, cyc = 0, base = 0, ca = 0, cb = 0;
  int first_low, low_a, q2_rise, busy_first, busy_last, err_na, low_b, err_nb;
  bit chk = 1'b0, tr = 1'b0;
  always #5 clk = ~clk;
  line_sync_pulse_gen #(.PULSE_LEN(PA), .HOLDOFF_LEN(HA), .LINES(LA), .EDGE_RISE(1'b0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_a), .i_sync(sync_a), .o_q(q_a), .o_q2(q2_a),
    .o_field(field_a), .o_line_cnt(line_a), .o_busy(busy_a), .o_err(err_a)
  );
  line_sync_pulse_gen #(.PULSE_LEN(PB), .HOLDOFF_LEN(HB), .LINES(LB), .EDGE_RISE(1'b1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_b), .i_sync(sync_b), .o_q(q_b), .o_q2(q2_b),
    .o_field(field_b), .o_line_cnt(line_b), .o_busy(busy_b), .o_err(err_b)
  );
  task automatic model_reset(input int k, input bit lvl);
    m[k].s1 = lvl; m[k].s2 = lvl; m[k].s3 = lvl;
    m[k].active = 1'b0; m[k].t = 0; m[k].line = 0;
    m[k].q = 1'b1; m[k].q2 = 1'b0; m[k].field = 1'b0; m[k].busy = 1'b0; m[k].err = 1'b0;
  endtask
  // A pulse accepted at edge t keeps Q low through edge t+p-1, completes at edge t+p,
  // and the block is ready for a new trigger only from edge t+p+h+1 onwards.
  task automatic model_step(input int k, input bit en, input bit sync, input bit rise,
                            input int p, input int h, input int lines, input int e);
    bit trig, idle;
    trig = rise ? (!m[k].s3 && m[k].s2) : (m[k].s3 && !m[k].s2);
    idle = !m[k].active || (e > m[k].t + p + h);
    m[k].err = 1'b0;
    if (!en) m[k].active = 1'b0;
    else begin
      if (m[k].active && e == m[k].t + p) m[k].q2 = !m[k].q2;
      if (trig && idle) begin
        m[k].active = 1'b1;
        m[k].t = e;
        m[k].line = (m[k].line + 1) % lines;
        if (m[k].line == 0) m[k].field = !m[k].field;
      end else if (trig) m[k].err = 1'b1;
    end
    m[k].q    = !(m[k].active && e <= m[k].t + p - 1);
    m[k].busy = m[k].active && (e <= m[k].t + p + h - 1);
    m[k].s3 = m[k].s2; m[k].s2 = m[k].s1; m[k].s1 = sync;
  endtask
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic trace_start();
    base = cyc; first_low = -1; low_a = 0; q2_rise = -1; busy_first = -1; busy_last = -1;
    err_na = 0; low_b = 0; err_nb = 0; tr = 1'b1;
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      model_reset(0, 1'b1);
      model_reset(1, 1'b0);
    end else begin
      cyc++;
      model_step(0, en_a, sync_a, 1'b0, PA, HA, LA, cyc);
      model_step(1, en_b, sync_b, 1'b1, PB, HB, LB, cyc);
    end
  always @(negedge clk) begin
    if (chk) begin
      check($sformatf("dut_a {q,q2,field,busy,err,line} @%0d", cyc),
            int'({q_a, q2_a, field_a, busy_a, err_a, line_a}),
            int'({m[0].q, m[0].q2, m[0].field, m[0].busy, m[0].err, m[0].line[8:0]}));
      check($sformatf("dut_b {q,q2,field,busy,err,line} @%0d", cyc),
            int'({q_b, q2_b, field_b, busy_b, err_b, line_b}),
            int'({m[1].q, m[1].q2, m[1].field, m[1].busy, m[1].err, m[1].line[1:0]}));
    end
    if (tr) begin
      if (!q_a) begin
        if (first_low < 0) first_low = cyc - base;
        low_a++;
      end
      if (q2_a && q2_rise < 0) q2_rise = cyc - base;
      if (busy_a) begin
        if (busy_first < 0) busy_first = cyc - base;
        busy_last = cyc - base;
      end
      err_na += int'(err_a);
      low_b  += int'(!q_b);
      err_nb += int'(err_b);
    end
  end
  initial begin
    model_reset(0, 1'b1);
    model_reset(1, 1'b0);
    wait_edges(3);
    check("reset q", int'(q_a), 1);
    check("reset q2", int'(q2_a), 0);
    check("reset line", int'(line_a), 0);
    check("reset field", int'(field_a), 0);
    check("reset busy", int'(busy_a), 0);
    check("reset err", int'(err_a), 0);
    chk = 1'b1;
    rst_n = 1'b1; en_a = 1'b1; en_b = 1'b1;
    wait_edges(1);
    // single falling edge at relative cycle 10
    trace_start();
    wait_edges(10); sync_a = 1'b0;
    wait_edges(20); sync_a = 1'b1;
    wait_edges(230);
    check("t1 first q low cycle", first_low, 13);
    check("t1 q low width", low_a, 11);
    check("t1 q2 rise cycle", q2_rise, 24);
    check("t1 busy first cycle", busy_first, 13);
    check("t1 busy last cycle", busy_last, 223);
    check("t1 err count", err_na, 0);
    check("t1 line", int'(line_a), 1);
    // retrigger inside holdoff, then a trigger on the first idle cycle
    trace_start();
    sync_a = 1'b0; wait_edges(20);
    sync_a = 1'b1; wait_edges(30);
    sync_a = 1'b0; wait_edges(20);
    sync_a = 1'b1; wait_edges(142);
    sync_a = 1'b0; wait_edges(20);
    sync_a = 1'b1; wait_edges(240);
    check("t2a q low cycles", low_a, 22);
    check("t2a err count", err_na, 1);
    check("t2a line", int'(line_a), 3);
    // trigger on the final holdoff cycle is ignored
    trace_start();
    sync_a = 1'b0; wait_edges(20);
    sync_a = 1'b1; wait_edges(191);
    sync_a = 1'b0; wait_edges(20);
    sync_a = 1'b1; wait_edges(240);
    check("t2b q low cycles", low_a, 11);
    check("t2b err count", err_na, 1);
    check("t2b line", int'(line_a), 4);
    // EN dropped at pulse cycle 5, re-raised with SYNC still low
    trace_start();
    sync_a = 1'b0; wait_edges(7);
    en_a = 1'b0; wait_edges(1);
    check("t3 abort q", int'(q_a), 1);
    check("t3 abort busy", int'(busy_a), 0);
    check("t3 abort q2", int'(q2_a), 0);
    check("t3 abort line", int'(line_a), 5);
    wait_edges(5); en_a = 1'b1; wait_edges(30);
    check("t3 no pulse low cycles", low_a, 5);
    check("t3 no pulse line", int'(line_a), 5);
    sync_a = 1'b1; wait_edges(10);
    sync_a = 1'b0; wait_edges(30);
    check("t3 fresh edge line", int'(line_a), 6);
    check("t3 fresh edge q2", int'(q2_a), 1);
    check("t3 fresh edge low cycles", low_a, 16);
    // asynchronous reset mid-holdoff
    wait_edges(100);
    check("t4 busy before reset", int'(busy_a), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t4 async q", int'(q_a), 1);
    check("t4 async q2", int'(q2_a), 0);
    check("t4 async line", int'(line_a), 0);
    check("t4 async field", int'(field_a), 0);
    check("t4 async busy", int'(busy_a), 0);
    en_a = 1'b0;
    wait_edges(2); rst_n = 1'b1;
    wait_edges(6); en_a = 1'b1;
    trace_start();
    wait_edges(20);
    check("t4 release line", int'(line_a), 0);
    check("t4 release low cycles", low_a, 0);
    // one full field of lines
    sync_a = 1'b1; wait_edges(10);
    for (int i = 0; i < LA; i++) begin
      sync_a = 1'b0; wait_edges(20);
      sync_a = 1'b1; wait_edges(209);
    end
    check("t5 field line", int'(line_a), 0);
    check("t5 field toggle", int'(field_a), 1);
    check("t5 field q2", int'(q2_a), 0);
    // rising-edge instance, edges 4 cycles apart then 2 cycles apart
    trace_start();
    for (int i = 0; i < 6; i++) begin
      sync_b = 1'b1; wait_edges(2);
      sync_b = 1'b0; wait_edges(2);
    end
    wait_edges(10);
    check("t6 b low cycles", low_b, 6);
    check("t6 b err count", err_nb, 0);
    check("t6 b line", int'(line_b), 2);
    check("t6 b field", int'(field_b), 1);
    trace_start();
    for (int i = 0; i < 4; i++) begin
      sync_b = 1'b1; wait_edges(1);
      sync_b = 1'b0; wait_edges(1);
    end
    wait_edges(10);
    check("t6 b2 low cycles", low_b, 4);
    check("t6 b2 err count", err_nb, 0);
    check("t6 b2 line", int'(line_b), 2);
    check("t6 b2 field", int'(field_b), 0);
    tr = 1'b0;
    // random SYNC and EN activity, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      if (ca == 0) begin sync_a = ~sync_a; ca = $urandom_range(1, 250); end
      else ca--;
      if (cb == 0) begin sync_b = ~sync_b; cb = $urandom_range(0, 5); end
      else cb--;
      en_a = ($urandom_range(0, 199) != 0);
      en_b = ($urandom_range(0, 49) != 0);
      wait_edges(1);
    end
    wait_edges(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
